// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle stage sequencer: fetch/mem handshakes, redirects, retire count, halt control
// Optional: CORE_SEQUENCER_MEM_SKIP_EN lets non-memory instructions bypass MEM.
module core_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        fetch_req,
  input  logic        fetch_ready,
  input  logic        exec_busy,
  input  logic        is_load,
  input  logic        is_store,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic        is_jump_enabled,
  input  logic [31:0] jump_dest,
  input  logic        halt_req,
  output logic        halted,
  output logic        timeout_err,
  output logic        misalign_err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      cur, nxt;
  logic [31:0] wait_cnt;
  logic        mem_op, misalign, timeout_hit;
  logic        wait_cycle, set_timeout, set_misalign;

  assign state       = cur;
  assign mem_op      = is_load | is_store;
  assign misalign    = is_jump_enabled && (jump_dest[1:0] != 2'b00);
  // A zero limit disables the timeout entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == 32'(TIMEOUT_CYCLES));

  always_comb begin
    nxt          = cur;
    fetch_req    = 1'b0;
    mem_req      = 1'b0;
    halted       = 1'b0;
    wait_cycle   = 1'b0;
    set_timeout  = 1'b0;
    set_misalign = 1'b0;
    case (cur)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ready) nxt = S_DECODE;
        else if (timeout_hit) begin
          nxt         = S_HALT;
          set_timeout = 1'b1;
        end else wait_cycle = 1'b1;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (!exec_busy) begin
`ifdef CORE_SEQUENCER_MEM_SKIP_EN
          nxt = mem_op ? S_MEM : S_WRITE;
`else
          nxt = S_MEM;
`endif
        end
      end
      S_MEM: begin
        if (mem_op) begin
          mem_req = 1'b1;
          if (mem_ready) nxt = S_WRITE;
          else if (timeout_hit) begin
            nxt         = S_HALT;
            set_timeout = 1'b1;
          end else wait_cycle = 1'b1;
        end else nxt = S_WRITE;
      end
      S_WRITE: begin
        if (misalign) begin
          nxt          = S_HALT;
          set_misalign = 1'b1;
        end else nxt = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= S_FETCH;
      pc           <= RESET_PC;
      retired      <= 32'd0;
      wait_cnt     <= 32'd0;
      timeout_err  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur) wait_cnt <= 32'd0;
      else if (wait_cycle) wait_cnt <= wait_cnt + 32'd1;
      if (set_timeout) timeout_err <= 1'b1;
      if (set_misalign) misalign_err <= 1'b1;
      // A misaligned redirect still retires but leaves pc on the faulting instruction.
      if (cur == S_WRITE) begin
        retired <= retired + 32'd1;
        if (!misalign) pc <= is_jump_enabled ? jump_dest : pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer against a per-instruction cycle plan
module tb_core_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam int T = 4;
  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state;
  logic [31:0] pc, retired, jump_dest;
  logic        fetch_req, fetch_ready, exec_busy, is_load, is_store;
  logic        mem_req, mem_ready, is_jump_enabled, halt_req;
  logic        halted, timeout_err, misalign_err;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(RPC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .state(state), .pc(pc),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready), .exec_busy(exec_busy),
    .is_load(is_load), .is_store(is_store), .mem_req(mem_req), .mem_ready(mem_ready),
    .is_jump_enabled(is_jump_enabled), .jump_dest(jump_dest), .halt_req(halt_req),
    .halted(halted), .timeout_err(timeout_err), .misalign_err(misalign_err), .retired(retired)
  );

  // One entry per expected clock cycle; -1 on an input means drive noise.
  typedef struct {
    int          st;
    int          fr;
    int          eb;
    int          mr;
    bit          mreq;
    logic [31:0] pc;
    logic [31:0] ret;
    bit          terr;
    bit          merr;
  } cyc_t;

  cyc_t        plan[$];
  logic [31:0] m_pc, m_ret;
  bit          m_terr, m_merr, m_halted;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input int st, input int fr, input int eb, input int mr, input bit mreq);
    cyc_t c;
    c.st = st; c.fr = fr; c.eb = eb; c.mr = mr; c.mreq = mreq;
    c.pc = m_pc; c.ret = m_ret; c.terr = m_terr; c.merr = m_merr;
    plan.push_back(c);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ret = 0; m_terr = 0; m_merr = 0; m_halted = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_F));
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_ret"}, retired, 32'd0);
    check({tag, "_freq"}, 32'(fetch_req), 32'd1);
    check({tag, "_mreq"}, 32'(mem_req), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    check({tag, "_merr"}, 32'(misalign_err), 32'd0);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; fetch_ready = 0; exec_busy = 0; mem_ready = 0;
    is_load = 0; is_store = 0; is_jump_enabled = 0; jump_dest = 0; halt_req = 0;
    #2;
    reset_checks("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_instr(input int fw, input int eb, input int mw, input bit ld, input bit st,
                           input bit jmp, input logic [31:0] dest, input bit hreq, input int hold);
    bit memop;
    memop = ld | st;
    plan.delete();
    if (fw > T) begin
      for (int k = 0; k <= T; k++) add(S_F, 0, -1, -1, 0);
      m_terr = 1; m_halted = 1;
    end else begin
      for (int k = 0; k <= fw; k++) add(S_F, (k == fw) ? 1 : 0, -1, -1, 0);
      add(S_D, -1, -1, -1, 0);
      for (int k = 0; k <= eb; k++) add(S_E, -1, (k < eb) ? 1 : 0, -1, 0);
      if (memop) begin
        if (mw > T) begin
          for (int k = 0; k <= T; k++) add(S_M, -1, -1, 0, 1);
          m_terr = 1; m_halted = 1;
        end else begin
          for (int k = 0; k <= mw; k++) add(S_M, -1, -1, (k == mw) ? 1 : 0, 1);
        end
      end else begin
`ifndef CORE_SEQUENCER_MEM_SKIP_EN
        add(S_M, -1, -1, -1, 0);
`endif
      end
      if (!m_halted) begin
        add(S_W, -1, -1, -1, 0);
        m_ret = m_ret + 1;
        if (jmp && dest[1:0] != 2'b00) begin
          m_merr = 1; m_halted = 1;
        end else begin
          m_pc = jmp ? dest : m_pc + 32'd4;
          if (hreq) m_halted = 1;
        end
      end
    end
    if (m_halted) for (int k = 0; k < hold; k++) add(S_H, -1, -1, -1, 0);

    is_load = ld; is_store = st; is_jump_enabled = jmp; jump_dest = dest; halt_req = hreq;
    foreach (plan[i]) begin
      fetch_ready = (plan[i].fr < 0) ? 1'($urandom) : 1'(plan[i].fr);
      exec_busy   = (plan[i].eb < 0) ? 1'($urandom) : 1'(plan[i].eb);
      mem_ready   = (plan[i].mr < 0) ? 1'($urandom) : 1'(plan[i].mr);
      @(negedge clk);
      check("state", 32'(state), 32'(plan[i].st));
      check("fetch_req", 32'(fetch_req), 32'(plan[i].st == S_F));
      check("mem_req", 32'(mem_req), 32'(plan[i].mreq));
      check("halted", 32'(halted), 32'(plan[i].st == S_H));
      check("pc", pc, plan[i].pc);
      check("retired", retired, plan[i].ret);
      check("timeout_err", 32'(timeout_err), 32'(plan[i].terr));
      check("misalign_err", 32'(misalign_err), 32'(plan[i].merr));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          fw, eb, mw;
    bit          ld, st, jmp, hreq;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    repeat (3) run_instr(0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    check("ret3", retired, 32'd3);
    check("pc3", pc, RPC + 32'd12);

    run_instr(0, 0, 3, 1, 0, 0, 32'd0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 0);
    check("branch_pc", pc, 32'h0000_0100);
    run_instr(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    run_instr(1, 1, 0, 0, 1, 0, 32'd0, 0, 0);
    check("wrap_pc", pc, 32'h0000_0000);

    run_instr(0, 0, 0, 0, 0, 1, 32'h0000_0102, 0, 3);
    check("misalign_pc", pc, 32'h0000_0000);
    do_reset();

    run_instr(T + 1, 0, 0, 0, 0, 0, 32'd0, 0, 3);
    do_reset();
    run_instr(T, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    run_instr(0, 0, T, 0, 1, 0, 32'd0, 0, 0);
    run_instr(0, 0, T + 1, 1, 0, 0, 32'd0, 0, 2);
    do_reset();

    run_instr(0, 5, 0, 0, 0, 0, 32'd0, 1, 4);
    check("halt_ret", retired, 32'd1);
    do_reset();

    // Asynchronous reset while a load is waiting in MEM.
    run_instr(0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    is_load = 1; is_store = 0; is_jump_enabled = 0; halt_req = 0;
    fetch_ready = 1; exec_busy = 0; mem_ready = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_state", 32'(state), 32'(S_M));
    check("mid_mreq", 32'(mem_req), 32'd1);
    check("mid_ret", retired, m_ret);
    #2 rst = 1'b1;
    #1 reset_checks("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 150; n++) begin
      fw   = $urandom_range(0, 5);
      eb   = $urandom_range(0, 4);
      mw   = $urandom_range(0, 5);
      ld   = ($urandom_range(0, 2) == 0);
      st   = !ld && ($urandom_range(0, 2) == 0);
      jmp  = ($urandom_range(0, 3) == 0);
      hreq = ($urandom_range(0, 15) == 0);
      d    = $urandom;
      d[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_instr(fw, eb, mw, ld, st, jmp, d, hreq, 2);
      if (m_halted) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
